// File: rtl/sync_debounce.sv
// sync_debounce: multi-flop synchronizer plus stability qualifier for a raw async level.
// Ports: iCLK, iRST_N, iSIG in; oSIG (debounced), oSYNC (raw sync), oBUSY (qualifying);
// oGLITCH_CNT (8b abort count) only when SYNC_DEBOUNCE_GLITCH_CNT_EN is defined.
module sync_debounce #(
  parameter int   SYNC_STAGES = 2,
  parameter int   DB_COUNT    = 16,
  parameter logic INIT_LEVEL  = 1'b0
) (
  input  logic       iCLK,
  input  logic       iRST_N,
  input  logic       iSIG,
  output logic       oSIG,
  output logic       oSYNC,
  output logic       oBUSY
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  ,
  output logic [7:0] oGLITCH_CNT
`endif
);

  localparam int CNT_W =
    (DB_COUNT > 1) ? $clog2(DB_COUNT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST =
    CNT_W'(DB_COUNT - 1);

  localparam logic [0:0] STABLE  = 1'b0;
  localparam logic [0:0] QUALIFY = 1'b1;

  logic [SYNC_STAGES-1:0] syncQ;
  logic [0:0]             stateQ;
  logic [CNT_W-1:0]       cntQ;
  logic                   mismatch;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      syncQ <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      syncQ <= {syncQ[SYNC_STAGES-2:0], iSIG};
    end
  end

  assign oSYNC    = syncQ[SYNC_STAGES-1];
  assign mismatch = oSYNC ^ oSIG;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      stateQ <= STABLE;
      cntQ   <= '0;
      oSIG   <= INIT_LEVEL;
    end else begin
      unique case (stateQ)
        STABLE: begin
          if (mismatch) begin
            // A single-clock qualify window needs no QUALIFY state.
            if (DB_COUNT == 1) begin
              oSIG <= oSYNC;
            end else begin
              stateQ <= QUALIFY;
              cntQ   <= CNT_W'(1);
            end
          end
        end
        QUALIFY: begin
          if (!mismatch) begin
            // Level fell back to oSIG: bounce, restart from zero.
            stateQ <= STABLE;
            cntQ   <= '0;
          end else if (cntQ == CNT_LAST) begin
            oSIG   <= oSYNC;
            stateQ <= STABLE;
            cntQ   <= '0;
          end else begin
            cntQ <= cntQ + CNT_W'(1);
          end
        end
        default: begin
          stateQ <= STABLE;
          cntQ   <= '0;
        end
      endcase
    end
  end

  assign oBUSY = (stateQ == QUALIFY);

`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic abort;

  assign abort = (stateQ == QUALIFY) && !mismatch;

  always_ff @(posedge iCLK or negedge iRST_N) begin
    if (!iRST_N) begin
      oGLITCH_CNT <= 8'h00;
    end else if (abort && (oGLITCH_CNT != 8'hFF)) begin
      oGLITCH_CNT <= oGLITCH_CNT + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_sync_debounce.sv
// tb_sync_debounce: random + directed bench for sync_debounce.
// Two instances: defaults, and SYNC_STAGES=3 / DB_COUNT=1.
module tb_sync_debounce;

  logic iCLK = 1'b0;
  logic iRST_N;
  logic iSIG;

  logic sigA, syncA, busyA;
  logic sigB, syncB, busyB;
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
  logic [7:0] gcA, gcB;
`endif

  always #5 iCLK = ~iCLK;

  sync_debounce dutA (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iSIG   (iSIG),
    .oSIG   (sigA),
    .oSYNC  (syncA),
    .oBUSY  (busyA)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .oGLITCH_CNT (gcA)
`endif
  );

  sync_debounce #(
    .SYNC_STAGES (3),
    .DB_COUNT    (1)
  ) dutB (
    .iCLK   (iCLK),
    .iRST_N (iRST_N),
    .iSIG   (iSIG),
    .oSIG   (sigB),
    .oSYNC  (syncB),
    .oBUSY  (busyB)
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    ,
    .oGLITCH_CNT (gcB)
`endif
  );

  int nChecks = 0;
  int nErrors = 0;
  int edgeN   = 0;

  // Reference model: oSYNC is iSIG delayed by the stage count;
  // oSIG follows once oSYNC has disagreed for D samples in a row.
  int   mS [2] = '{2, 3};
  int   mD [2] = '{16, 1};
  logic q0 [$];
  logic q1 [$];
  logic mSync [2];
  logic mOut [2];
  int   mRun [2];
  int   mGl [2];

  int   chgSigA, chgSyncA, chgSigB, chgSyncB;
  logic prevSigA, prevSyncA, prevSigB, prevSyncB;
  logic prevBusyA;
  int   busyRiseA, busyHighA;
  logic busyBSeen;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    nChecks++;
    if (got !== exp) begin
      nErrors++;
      $display("FAIL %s @edge %0d: got %0h expected %0h",
               tag, edgeN, got, exp);
    end
  endtask

  function automatic void modelReset();
    for (int i = 0; i < 2; i++) begin
      mSync[i] = 1'b0;
      mOut[i]  = 1'b0;
      mRun[i]  = 0;
      mGl[i]   = 0;
    end
    q0.delete();
    q1.delete();
  endfunction

  function automatic void modelQual(input int i);
    if (mSync[i] != mOut[i]) begin
      mRun[i]++;
      if (mRun[i] == mD[i]) begin
        mOut[i] = mSync[i];
        mRun[i] = 0;
      end
    end else begin
      if (mRun[i] > 0 && mGl[i] < 255) mGl[i]++;
      mRun[i] = 0;
    end
  endfunction

  function automatic void modelStep();
    if (!iRST_N) begin
      modelReset();
    end else begin
      modelQual(0);
      modelQual(1);
      q0.push_back(iSIG);
      if (q0.size() > mS[0]) void'(q0.pop_front());
      mSync[0] = (q0.size() == mS[0]) ? q0[0] : 1'b0;
      q1.push_back(iSIG);
      if (q1.size() > mS[1]) void'(q1.pop_front());
      mSync[1] = (q1.size() == mS[1]) ? q1[0] : 1'b0;
    end
  endfunction

  task automatic checkAll();
    check("syncA", syncA, mSync[0]);
    check("sigA",  sigA,  mOut[0]);
    check("busyA", busyA, mRun[0] > 0);
    check("syncB", syncB, mSync[1]);
    check("sigB",  sigB,  mOut[1]);
    check("busyB", busyB, mRun[1] > 0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("gcA", gcA, mGl[0]);
    check("gcB", gcB, mGl[1]);
`endif
  endtask

  task automatic track();
    if (sigA !== prevSigA)   chgSigA  = edgeN;
    if (syncA !== prevSyncA) chgSyncA = edgeN;
    if (sigB !== prevSigB)   chgSigB  = edgeN;
    if (syncB !== prevSyncB) chgSyncB = edgeN;
    if (busyA && !prevBusyA) busyRiseA++;
    if (busyA) busyHighA++;
    if (busyB) busyBSeen = 1'b1;
    prevSigA  = sigA;
    prevSyncA = syncA;
    prevSigB  = sigB;
    prevSyncB = syncB;
    prevBusyA = busyA;
  endtask

  task automatic clearChg();
    chgSigA   = -1;
    chgSyncA  = -1;
    chgSigB   = -1;
    chgSyncB  = -1;
    busyRiseA = 0;
    busyHighA = 0;
  endtask

  // Drive at negedge, step model at posedge, compare at next negedge.
  task automatic cycle(input logic s);
    iSIG = s;
    @(posedge iCLK);
    edgeN++;
    modelStep();
    @(negedge iCLK);
    track();
    checkAll();
  endtask

  task automatic hold(input logic s, input int n);
    repeat (n) cycle(s);
  endtask

  int   s0;
  logic [7:0] gcSnap;

  initial begin
    iRST_N    = 1'b0;
    iSIG      = 1'b0;
    busyBSeen = 1'b0;
    prevSigA  = 1'b0;
    prevSyncA = 1'b0;
    prevSigB  = 1'b0;
    prevSyncB = 1'b0;
    prevBusyA = 1'b0;
    clearChg();
    modelReset();
    @(negedge iCLK);
    checkAll();

    // Reset holds everything while iSIG toggles.
    for (int i = 0; i < 6; i++) cycle(1'(i & 1));
    check("rstSig", sigA, 1'b0);
    check("rstBusy", busyA, 1'b0);

    iRST_N = 1'b1;
    hold(1'b0, 5);

    // Bounce: two aborted qualifications.
    clearChg();
    hold(1'b1, 5);
    hold(1'b0, 4);
    hold(1'b1, 3);
    hold(1'b0, 25);
    check("bounceSig", sigA, 1'b0);
    check("bouncePulses", busyRiseA, 2);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("bounceGc", gcA, 8'd2);
`endif

    // Clean rise.
    clearChg();
    s0 = edgeN;
    hold(1'b1, 25);
    check("riseSyncA", chgSyncA - s0, 2);
    check("riseSigA", chgSigA - s0, 18);
    check("riseBusyA", busyHighA, 15);
    check("riseSyncB", chgSyncB - s0, 3);
    check("riseSigB", chgSigB - s0, 4);

    // Fall after qualified rise.
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    gcSnap = gcA;
`endif
    clearChg();
    s0 = edgeN;
    hold(1'b0, 20);
    check("fallSigA", chgSigA - s0, 18);
    check("fallLevel", sigA, 1'b0);
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("fallGc", gcA, gcSnap);
`endif

    // Reset in the middle of a qualification.
    hold(1'b1, 10);
    check("midBusy", busyA, 1'b1);
    iRST_N = 1'b0;
    #1;
    modelReset();
    check("midRstBusy", busyA, 1'b0);
    check("midRstCnt", dutA.cntQ, 0);
    check("midRstSig", sigA, 1'b0);
    check("midRstSync", syncA, 1'b0);
    track();
    cycle(1'b1);
    iRST_N = 1'b1;
    clearChg();
    s0 = edgeN;
    hold(1'b1, 22);
    check("relSigA", chgSigA - s0, 18);

    // Random hold lengths.
    repeat (120) begin
      hold(1'($urandom_range(0, 1)),
           int'($urandom_range(1, 24)));
    end

    // Many short pulses to drive aborts.
    hold(1'b0, 25);
    repeat (300) begin
      hold(1'b1, 3);
      hold(1'b0, 3);
    end
`ifdef SYNC_DEBOUNCE_GLITCH_CNT_EN
    check("gcSat", gcA, 8'hFF);
`endif
    check("busyBNever", busyBSeen, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors",
             nChecks, nErrors);
    $finish;
  end

endmodule
